// File: rtl/swc_mpm_page_allocator_pkg.sv
// Shared types and helpers for the multi-port page allocator.
package swc_mpm_page_allocator_pkg;

  typedef enum logic [1:0] {ALLOC, FREE, FORCE_FREE, SET_USECOUNT} t_alloc_op;
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_UPDATE} t_alloc_state;

  // Ceiling log2, never below 1 so that a single-port build still has a 1-bit index.
  function automatic int f_log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/swc_mpm_page_allocator_if.sv
// Requester-side bus of the page allocator: per-port requests in, shared results out.
interface swc_mpm_page_allocator_if #(
  parameter int g_page_addr_width = 10,
  parameter int g_usecnt_width    = 4,
  parameter int g_num_ports       = 4
);
  logic [g_num_ports-1:0]                   alloc_i;
  logic [g_num_ports-1:0]                   free_i;
  logic [g_num_ports-1:0]                   force_free_i;
  logic [g_num_ports-1:0]                   set_usecnt_i;
  logic [g_num_ports*g_page_addr_width-1:0] pg_addr_i;
  logic [g_num_ports*g_usecnt_width-1:0]    usecnt_i;
  logic [g_num_ports-1:0]                   done_o;
  logic [g_page_addr_width-1:0]             pg_addr_alloc_o;
  logic                                     free_last_usecnt_o;
  logic                                     err_o;
  logic                                     nomem_o;
  logic [g_page_addr_width:0]               free_pages_o;
  logic                                     ready_o;

  modport master (
    output alloc_i, free_i, force_free_i, set_usecnt_i, pg_addr_i, usecnt_i,
    input  done_o, pg_addr_alloc_o, free_last_usecnt_o, err_o, nomem_o, free_pages_o, ready_o
  );

  modport slave (
    input  alloc_i, free_i, force_free_i, set_usecnt_i, pg_addr_i, usecnt_i,
    output done_o, pg_addr_alloc_o, free_last_usecnt_o, err_o, nomem_o, free_pages_o, ready_o
  );
endinterface

// File: rtl/swc_mpm_page_allocator_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the pointer.
module swc_mpm_page_allocator_rr_arbiter
  import swc_mpm_page_allocator_pkg::*;
#(
  parameter int   g_width = 4,
  localparam int  c_pw    = f_log2(g_width)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [g_width-1:0] req,
  output logic [g_width-1:0] grant,
  output logic [c_pw-1:0]    grant_idx,
  output logic               grant_valid
);
  logic [c_pw-1:0] ptr_reg;
  logic [c_pw-1:0] idx;

  // Scan from the far end back towards the pointer so the nearest request wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = g_width - 1; k >= 0; k--) begin
      idx = c_pw'((int'(ptr_reg) + k) % g_width);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_reg <= '0;
    end else if (grant_valid) begin
      ptr_reg <= (grant_idx == c_pw'(g_width - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/swc_mpm_page_allocator.sv
// Multi-port page allocator: RR-arbitrated alloc/free/force_free/set_usecnt over a shared
// free-page FIFO and a per-page {allocated, use count} RAM.
module swc_mpm_page_allocator
  import swc_mpm_page_allocator_pkg::*;
#(
  parameter int g_num_pages       = 1024,
  parameter int g_page_addr_width = 10,
  parameter int g_usecnt_width    = 4,
  parameter int g_num_ports       = 4
) (
  input logic                     clk_i,
  input logic                     rst_n_i,
  swc_mpm_page_allocator_if.slave bus
);
  localparam int c_aw = g_page_addr_width;
  localparam int c_uw = g_usecnt_width;
  localparam int c_np = g_num_ports;
  localparam int c_pw = f_log2(c_np);
  localparam logic [c_aw:0]   c_num_pages = (c_aw + 1)'(g_num_pages);
  localparam logic [c_aw-1:0] c_last_page = c_aw'(g_num_pages - 1);

  t_alloc_state    state_reg;
  t_alloc_op       op_reg, sel_op;
  logic [c_aw-1:0] init_cnt_reg, rd_ptr_reg, wr_ptr_reg, page_reg, pg_addr_alloc_reg;
  logic [c_aw:0]   free_pages_reg;
  logic [c_uw-1:0] usecnt_reg;
  logic [c_np-1:0] grant_reg, done_reg, eligible, grant_vec;
  logic [c_pw-1:0] grant_idx;
  logic            grant_valid, ready_reg, free_last_reg, err_reg, pool_empty;

  logic [c_aw-1:0] port_addr [c_np];
  logic [c_uw-1:0] port_cnt  [c_np];

  // Each page word is {allocated bit, use count}; zero means free.
  logic [c_uw:0]   meta_mem [g_num_pages];
  logic [c_aw-1:0] fifo_mem [g_num_pages];
  logic [c_uw:0]   meta_rd, meta_wdata;
  logic [c_aw-1:0] fifo_rd, meta_waddr, fifo_waddr, fifo_wdata;
  logic            meta_we, fifo_we, do_release, upd_err;

  assign pool_empty = (free_pages_reg == '0);

  // A port whose done is showing is masked so a held request is not served twice.
  generate
    for (genvar gi = 0; gi < c_np; gi++) begin : g_port
      assign port_addr[gi] = bus.pg_addr_i[gi*c_aw +: c_aw];
      assign port_cnt[gi]  = bus.usecnt_i[gi*c_uw +: c_uw];
      assign eligible[gi]  = (state_reg == S_IDLE) && !done_reg[gi] &&
                             (bus.force_free_i[gi] || bus.free_i[gi] || bus.set_usecnt_i[gi] ||
                              (bus.alloc_i[gi] && !pool_empty));
    end
  endgenerate

  swc_mpm_page_allocator_rr_arbiter #(.g_width(c_np)) u_arb (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req         (eligible),
    .grant       (grant_vec),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_op = ALLOC;
    if (bus.force_free_i[grant_idx])      sel_op = FORCE_FREE;
    else if (bus.free_i[grant_idx])       sel_op = FREE;
    else if (bus.set_usecnt_i[grant_idx]) sel_op = SET_USECOUNT;
  end

  always_comb begin
    upd_err    = 1'b0;
    do_release = 1'b0;
    meta_we    = 1'b0;
    meta_waddr = page_reg;
    meta_wdata = '0;
    fifo_we    = 1'b0;
    fifo_waddr = wr_ptr_reg;
    fifo_wdata = page_reg;
    if (state_reg == S_INIT) begin
      meta_we    = 1'b1;
      meta_waddr = init_cnt_reg;
      fifo_we    = 1'b1;
      fifo_waddr = init_cnt_reg;
      fifo_wdata = init_cnt_reg;
    end else if (state_reg == S_UPDATE) begin
      case (op_reg)
        ALLOC: begin
          meta_we    = 1'b1;
          meta_waddr = fifo_rd;
          meta_wdata = {1'b1, usecnt_reg};
        end
        FREE: begin
          if (!meta_rd[c_uw]) upd_err = 1'b1;
          else if (meta_rd[c_uw-1:0] <= c_uw'(1)) do_release = 1'b1;
          else begin
            meta_we    = 1'b1;
            meta_wdata = {1'b1, meta_rd[c_uw-1:0] - 1'b1};
          end
        end
        FORCE_FREE: begin
          if (meta_rd[c_uw]) do_release = 1'b1;
          else               upd_err    = 1'b1;
        end
        SET_USECOUNT: begin
          if (!meta_rd[c_uw]) upd_err = 1'b1;
          else if (usecnt_reg == '0) do_release = 1'b1;
          else begin
            meta_we    = 1'b1;
            meta_wdata = {1'b1, usecnt_reg};
          end
        end
        default: ;
      endcase
      if (do_release) begin
        meta_we = 1'b1;
        fifo_we = (free_pages_reg != c_num_pages);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (meta_we) meta_mem[meta_waddr] <= meta_wdata;
    if (fifo_we) fifo_mem[fifo_waddr] <= fifo_wdata;
    meta_rd <= meta_mem[page_reg];
    fifo_rd <= fifo_mem[rd_ptr_reg];
  end

  function automatic logic [c_aw-1:0] ptr_inc(input logic [c_aw-1:0] p);
    return (p == c_last_page) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg         <= S_INIT;
      op_reg            <= ALLOC;
      init_cnt_reg      <= '0;
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      page_reg          <= '0;
      usecnt_reg        <= '0;
      grant_reg         <= '0;
      free_pages_reg    <= '0;
      ready_reg         <= 1'b0;
      done_reg          <= '0;
      pg_addr_alloc_reg <= '0;
      free_last_reg     <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      done_reg      <= '0;
      free_last_reg <= 1'b0;
      err_reg       <= 1'b0;
      case (state_reg)
        S_INIT: begin
          init_cnt_reg   <= init_cnt_reg + 1'b1;
          free_pages_reg <= free_pages_reg + 1'b1;
          if (init_cnt_reg == c_last_page) begin
            ready_reg <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (grant_valid) begin
            op_reg     <= sel_op;
            page_reg   <= port_addr[grant_idx];
            usecnt_reg <= port_cnt[grant_idx];
            grant_reg  <= grant_vec;
            state_reg  <= S_READ;
          end
        end
        S_READ: state_reg <= S_UPDATE;
        S_UPDATE: begin
          done_reg      <= grant_reg;
          err_reg       <= upd_err;
          free_last_reg <= do_release;
          if (op_reg == ALLOC) begin
            pg_addr_alloc_reg <= fifo_rd;
            rd_ptr_reg        <= ptr_inc(rd_ptr_reg);
            free_pages_reg    <= free_pages_reg - 1'b1;
          end else if (fifo_we) begin
            wr_ptr_reg     <= ptr_inc(wr_ptr_reg);
            free_pages_reg <= free_pages_reg + 1'b1;
          end
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_INIT;
      endcase
    end
  end

  assign bus.done_o             = done_reg;
  assign bus.pg_addr_alloc_o    = pg_addr_alloc_reg;
  assign bus.free_last_usecnt_o = free_last_reg;
  assign bus.err_o              = err_reg;
  assign bus.nomem_o            = ready_reg && pool_empty;
  assign bus.free_pages_o       = free_pages_reg;
  assign bus.ready_o            = ready_reg;
endmodule

// File: tb/tb_swc_mpm_page_allocator.sv
// Directed and randomized checks of the page allocator against a queue-based pool model.
module tb_swc_mpm_page_allocator;
  localparam int NP = 16;
  localparam int OP_ALLOC = 0, OP_FREE = 1, OP_FORCE = 2, OP_SET = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  swc_mpm_page_allocator_if #(.g_page_addr_width(4), .g_usecnt_width(4), .g_num_ports(4)) bus ();

  swc_mpm_page_allocator #(
    .g_num_pages(NP), .g_page_addr_width(4), .g_usecnt_width(4), .g_num_ports(4)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_miss = 0;

  // Per-port pending request of the current batch.
  bit pend [4];
  int op_b [4];
  int addr_b [4];
  int cnt_b [4];

  // Reference pool: FIFO of free pages, per-page allocation flag and use count, RR pointer.
  int fq [$];
  bit m_alloc [NP];
  int m_cnt [NP];
  int m_ptr;
  int exp_err, exp_last, exp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    fq.delete();
    for (int i = 0; i < NP; i++) begin
      fq.push_back(i);
      m_alloc[i] = 1'b0;
      m_cnt[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic model_release(input int a);
    m_alloc[a] = 1'b0;
    m_cnt[a] = 0;
    if (fq.size() < NP) fq.push_back(a);
    exp_last = 1;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (m_ptr + k) % 4;
      if (pend[p] && (op_b[p] != OP_ALLOC || fq.size() > 0)) begin
        m_ptr = (p + 1) % 4;
        return p;
      end
    end
    return -1;
  endfunction

  task automatic model_exec(input int e);
    int a;
    a = addr_b[e];
    exp_err = 0;
    exp_last = 0;
    case (op_b[e])
      OP_ALLOC: begin
        exp_addr = fq.pop_front();
        m_alloc[exp_addr] = 1'b1;
        m_cnt[exp_addr] = cnt_b[e];
      end
      OP_FREE: begin
        if (!m_alloc[a]) exp_err = 1;
        else if (m_cnt[a] <= 1) model_release(a);
        else m_cnt[a] = m_cnt[a] - 1;
      end
      OP_FORCE: begin
        if (m_alloc[a]) model_release(a);
        else exp_err = 1;
      end
      default: begin
        if (!m_alloc[a]) exp_err = 1;
        else if (cnt_b[e] == 0) model_release(a);
        else m_cnt[a] = cnt_b[e];
      end
    endcase
  endtask

  task automatic drive_all();
    for (int p = 0; p < 4; p++) begin
      bus.alloc_i[p]      = pend[p] && op_b[p] == OP_ALLOC;
      bus.free_i[p]       = pend[p] && op_b[p] == OP_FREE;
      bus.force_free_i[p] = pend[p] && op_b[p] == OP_FORCE;
      bus.set_usecnt_i[p] = pend[p] && op_b[p] == OP_SET;
      bus.pg_addr_i[p*4 +: 4] = 4'(addr_b[p]);
      bus.usecnt_i[p*4 +: 4]  = 4'(cnt_b[p]);
    end
  endtask

  task automatic req(input int p, input int op, input int a, input int c);
    pend[p] = 1'b1;
    op_b[p] = op;
    addr_b[p] = a;
    cnt_b[p] = c;
  endtask

  // Issues all pending requests together and checks each completion in model order.
  task automatic run_batch();
    int e, gap, left;
    drive_all();
    left = 0;
    for (int p = 0; p < 4; p++) if (pend[p]) left++;
    while (left > 0) begin
      e = model_pick();
      if (e < 0) begin
        gap = 0;
        repeat (8) begin
          @(negedge clk);
          if (bus.done_o != '0) gap++;
        end
        check("no_grant_when_empty", 32'(gap), 0);
        for (int p = 0; p < 4; p++) pend[p] = 1'b0;
        drive_all();
        left = 0;
      end else begin
        gap = 0;
        do begin
          @(negedge clk);
          gap++;
        end while (bus.done_o == '0 && gap < 20);
        model_exec(e);
        $display("port%0d op%0d addr%0d cnt%0d -> done=%b err=%0d last=%0d pg=%0d free=%0d",
                 e, op_b[e], addr_b[e], cnt_b[e], bus.done_o, bus.err_o,
                 bus.free_last_usecnt_o, bus.pg_addr_alloc_o, bus.free_pages_o);
        check("latency", 32'(gap), 3);
        check("done", 32'(bus.done_o), 32'(1 << e));
        check("err", 32'(bus.err_o), 32'(exp_err));
        check("free_last", 32'(bus.free_last_usecnt_o), 32'(exp_last));
        check("free_pages", 32'(bus.free_pages_o), 32'(fq.size()));
        check("nomem", 32'(bus.nomem_o), 32'(fq.size() == 0));
        if (op_b[e] == OP_ALLOC) check("pg_addr_alloc", 32'(bus.pg_addr_alloc_o), 32'(exp_addr));
        pend[e] = 1'b0;
        drive_all();
        left--;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    int cyc;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready_o), 0);
    check("rst_free_pages", 32'(bus.free_pages_o), 0);
    check("rst_done", 32'(bus.done_o), 0);
    check("rst_nomem", 32'(bus.nomem_o), 0);
    check("rst_err", 32'(bus.err_o), 0);
    check("rst_last", 32'(bus.free_last_usecnt_o), 0);
    check("rst_pg_addr", 32'(bus.pg_addr_alloc_o), 0);
    for (int p = 0; p < 4; p++) pend[p] = 1'b0;
    drive_all();
    rst_n = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.ready_o && cyc < 100);
    $display("reset released, ready after %0d clocks, free=%0d", cyc, bus.free_pages_o);
    check("init_cycles", 32'(cyc), NP);
    check("init_free_pages", 32'(bus.free_pages_o), NP);
    check("init_nomem", 32'(bus.nomem_o), 0);
    model_init();
  endtask

  initial begin
    int pg;
    for (int p = 0; p < 4; p++) begin
      pend[p] = 1'b0;
      op_b[p] = OP_ALLOC;
      addr_b[p] = 0;
      cnt_b[p] = 0;
    end
    drive_all();
    @(negedge clk);
    do_reset();

    // Drain the pool from one port: pages come out 0..15 in order.
    for (int i = 0; i < NP; i++) begin
      req(0, OP_ALLOC, 0, 1);
      run_batch();
    end
    check("nomem_after_drain", 32'(bus.nomem_o), 1);

    // Empty pool: a lone alloc is never granted, then a free feeds it page 3.
    req(1, OP_ALLOC, 0, 1);
    run_batch();
    req(1, OP_ALLOC, 0, 1);
    req(0, OP_FREE, 3, 0);
    run_batch();
    check("nomem_after_refill", 32'(bus.nomem_o), 1);

    // Page 5 with use count 3 needs three frees.
    req(0, OP_FORCE, 5, 0);
    run_batch();
    req(0, OP_ALLOC, 0, 3);
    run_batch();
    for (int i = 0; i < 3; i++) begin
      req(0, OP_FREE, 5, 0);
      run_batch();
    end

    // Return pages 8..15, then two four-way alloc races with different pointer positions.
    for (int i = 8; i < NP; i++) begin
      req(2, OP_FORCE, i, 0);
      run_batch();
    end
    req(3, OP_FORCE, 0, 0);
    run_batch();
    for (int p = 0; p < 4; p++) req(p, OP_ALLOC, 0, 1 + p);
    run_batch();
    req(1, OP_SET, 1, 1);
    run_batch();
    for (int p = 0; p < 4; p++) req(p, OP_ALLOC, 0, 2);
    run_batch();

    // Illegal frees of an unallocated page.
    req(0, OP_FORCE, 7, 0);
    run_batch();
    req(0, OP_FREE, 7, 0);
    run_batch();
    req(0, OP_FORCE, 7, 0);
    run_batch();

    // Reserved page: alloc with zero count, set it, then force it back.
    pg = fq[0];
    req(2, OP_ALLOC, 0, 0);
    run_batch();
    req(2, OP_SET, pg, 2);
    run_batch();
    req(2, OP_FORCE, pg, 0);
    run_batch();

    // Randomized batches.
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 4; p++)
        if ($urandom_range(0, 1) == 1)
          req(p, int'($urandom_range(0, 3)), int'($urandom_range(0, NP - 1)), int'($urandom_range(0, 3)));
      run_batch();
    end

    // Reset while an operation sits in the read stage.
    req(0, OP_FORCE, 0, 0);
    drive_all();
    @(negedge clk);
    do_reset();
    req(3, OP_ALLOC, 0, 1);
    run_batch();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
